seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display path. It holds eight 4-bit digit values and cycles the digit-select and nibble outputs that feed the combinational digit/segment decoder, one digit per refresh slot. Updates go to a shadow register file and are committed to the display at a frame boundary, so a frame never shows a mix of old and new digits. An anti-ghosting blank interval is inserted at every digit change.

---
 rtl/seg_scan_ctrl.sv | 106 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: steps one digit per refresh slot, blanks each slot's start,
// and commits shadow digits to the active set only at frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic [7:0] digit_en,
    output logic [3:0] num,
    output logic [2:0] sel,
    output logic       blank,
    output logic       frame_tick,
    output logic       commit_pending
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    sel_q, sel_d;
    logic          blank_q, blank_d;
    logic          tick_q, tick_d;
    logic          pend_q, pend_d;
    logic          slot_end, boundary, copy_now;
    logic [3:0]    shadow_q [8];
    logic [3:0]    active_q [8];

    always_comb begin
        slot_end = (div_q == DIV_LAST);
        boundary = slot_end && (sel_q == 3'd7);
        copy_now = boundary && (pend_q || commit);
        div_d    = slot_end ? '0 : div_q + CW'(1);
        sel_d    = slot_end ? sel_q + 3'd1 : sel_q;
        state_d  = state_q;
        // With no blank interval every slot starts straight in SHOW; BLANK is then only seen right after reset.
        if (slot_end) begin
            state_d = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
        end else if (state_q == ST_BLANK && (BLANK_CYC == 0 || div_q == BLANK_LAST)) begin
            state_d = ST_SHOW;
        end
        blank_d = (state_d == ST_BLANK) ? 1'b1 : ~digit_en[sel_d];
        tick_d  = boundary;
        pend_d  = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
        end else if (commit) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            div_q   <= '0;
            sel_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
        end
    end

    // The copy reads pre-edge shadow, so a same-edge write waits for a later commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow_q[wr_addr] <= wr_data;
            end
            if (copy_now) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign num            = active_q[sel_q];
    assign sel            = sel_q;
    assign blank          = blank_q;
    assign frame_tick     = tick_q;
    assign commit_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: REFRESH_DIV=4 with BLANK_CYC=1 (main) and BLANK_CYC=0 (second build).
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       commit = 1'b0;
    logic [7:0] digit_en = 8'hFF;
    logic [3:0] num, num0;
    logic [2:0] sel, sel0;
    logic       blank, blank0, frame_tick, frame_tick0, pend, pend0;
    int         checks = 0;
    int         errors = 0;
    int unsigned cyc;

    seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .digit_en(digit_en), .num(num), .sel(sel), .blank(blank),
        .frame_tick(frame_tick), .commit_pending(pend)
    );

    seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .digit_en(digit_en), .num(num0), .sel(sel0), .blank(blank0),
        .frame_tick(frame_tick0), .commit_pending(pend0)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: slot = cyc/4, frame position = cyc%32.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [2:0] exp_sel();
        return 3'((cyc / 4) % 8);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_pos(input int unsigned m);
        for (int i = 0; i < 64 && (cyc % 32) != m; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", blank); end
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL reset_num got %h exp 0", num); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 70; i++) begin
            checks++; if (sel !== exp_sel()) begin errors++; $display("FAIL scan_sel cyc %0d got %0d exp %0d", cyc, sel, exp_sel()); end
            checks++; if (blank !== (cyc % 4 == 0)) begin errors++; $display("FAIL scan_blank cyc %0d got %b exp %b", cyc, blank, cyc % 4 == 0); end
            checks++; if (frame_tick !== (cyc % 32 == 0 && cyc != 0)) begin errors++; $display("FAIL scan_tick cyc %0d got %b", cyc, frame_tick); end
            checks++; if (sel0 !== exp_sel()) begin errors++; $display("FAIL scan0_sel cyc %0d got %0d exp %0d", cyc, sel0, exp_sel()); end
            checks++; if (blank0 !== (cyc == 0)) begin errors++; $display("FAIL scan0_blank cyc %0d got %b exp %b", cyc, blank0, cyc == 0); end
            step();
        end
    endtask

    task automatic test_tear_free();
        wait_pos(8);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
        step();
        wr_en = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL tf_pend_set got %b exp 1", pend); end
        for (int i = 0; i < 40 && (cyc % 32) != 0; i++) begin
            if (exp_sel() == 3'd3) begin
                checks++; if (num !== 4'h0) begin errors++; $display("FAIL tf_num_old cyc %0d got %h exp 0", cyc, num); end
            end
            checks++; if (pend !== 1'b1) begin errors++; $display("FAIL tf_pend_hold cyc %0d got %b exp 1", cyc, pend); end
            step();
        end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL tf_pend_clr got %b exp 0", pend); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL tf_tick got %b exp 1", frame_tick); end
        wait_pos(13);
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL tf_sel got %0d exp 3", sel); end
        checks++; if (num !== 4'hA) begin errors++; $display("FAIL tf_num_new got %h exp a", num); end
    endtask

    task automatic test_simultaneous();
        wait_pos(20);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'h7;
        step();
        wr_en = 1'b0;
        wait_pos(31);
        commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
        step();
        commit = 1'b0; wr_en = 1'b0;
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL sim_pend got %b exp 0", pend); end
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL sim_tick got %b exp 1", frame_tick); end
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL sim_num0 got %h exp 0", num); end
        wait_pos(5);
        checks++; if (num !== 4'h7) begin errors++; $display("FAIL sim_num1 got %h exp 7", num); end
        wait_pos(0);
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL sim_num0_nocommit got %h exp 0", num); end
        commit = 1'b1;
        step();
        commit = 1'b0;
        wait_pos(0);
        checks++; if (num !== 4'h5) begin errors++; $display("FAIL sim_num0_late got %h exp 5", num); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL sim_pend_late got %b exp 0", pend); end
    endtask

    task automatic test_masking();
        wait_pos(16);
        digit_en = 8'b1111_1110;
        wait_pos(0);
        for (int i = 0; i < 32; i++) begin
            checks++; if (blank !== ((exp_sel() == 3'd0) || (cyc % 4 == 0))) begin errors++; $display("FAIL mask_blank cyc %0d got %b", cyc, blank); end
            checks++; if (blank0 !== (exp_sel() == 3'd0)) begin errors++; $display("FAIL mask0_blank cyc %0d got %b", cyc, blank0); end
            step();
        end
        digit_en = 8'hFF;
    endtask

    task automatic test_reset_mid();
        wait_pos(18);
        commit = 1'b1;
        step();
        commit = 1'b0;
        wait_pos(21);
        checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rm_pend_pre got %b exp 1", pend); end
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL rm_sel_pre got %0d exp 5", sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rm_sel got %0d exp 0", sel); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rm_blank got %b exp 1", blank); end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rm_pend got %b exp 0", pend); end
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL rm_num got %h exp 0", num); end
        @(negedge clk);
        rst_n = 1'b1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        wait_pos(0);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL rm_tick got %b exp 1", frame_tick); end
        wait_pos(5);
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL rm_shadow1 got %h exp 0", num); end
        wait_pos(13);
        checks++; if (num !== 4'h0) begin errors++; $display("FAIL rm_shadow3 got %h exp 0", num); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_simultaneous();
        test_masking();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
